// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data load/store.
// Data wins ties, transactions are never preempted, and a stuck access times out with bus_err.
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          if_stall,
  output logic          d_stall,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StIfBusy, StDBusy} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  logic busy, timeout, finish, if_fin, d_fin, arb, if_elig, d_elig;

  always_comb begin
    busy    = (state_q != StIdle);
    timeout = busy && !mem_ready && (cnt_q == CW'(WAIT_MAX - 1));
    finish  = busy && (mem_ready || timeout);
    if_fin  = finish && (state_q == StIfBusy);
    d_fin   = finish && (state_q == StDBusy);
    arb     = !busy || finish;
    // A requester finishing now, or whose done is showing, still holds req this cycle.
    if_elig = if_req && !if_done && !if_fin;
    d_elig  = d_req && !d_done && !d_fin;
  end

  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_done <= if_fin;
      d_done  <= d_fin;
      bus_err <= timeout;

      if (if_fin) begin
        if_rdata <= timeout ? '0 : mem_rdata;
      end
      // Stores leave the load data register untouched.
      if (d_fin && !mem_we) begin
        d_rdata <= timeout ? '0 : mem_rdata;
      end

      if (busy && !finish) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end

      if (arb) begin
        if (d_elig) begin
          state_q   <= StDBusy;
          mem_req   <= 1'b1;
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else if (if_elig) begin
          state_q   <= StIfBusy;
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end else begin
          state_q <= StIdle;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      end
    end
  end

endmodule
